alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Upstream command stage for the 16-bit combinational ALU. It accepts {op, A, B, tag}
//  commands on a valid/ready port and buffers them in a DEPTH-entry FIFO.
//  It issues the FIFO head to an internally instantiated ALU and registers
//  RESULT/CARRY/ZERO plus tag into an output stage with its own valid/ready handshake.
//  It decouples command producers from result consumers at one op per cycle.
// PARAMETERS
//  N      16  operand/result width; must be >= 4 (shift amount is B[3:0])
//  DEPTH  4   command FIFO entries; power of 2, >= 2
//  TAG_W  4   width of opaque tag carried alongside each command
// PORTS
//  clk         in   1                  rising-edge clock
//  rst         in   1                  synchronous reset, active-high
//  in_valid    in   1                  command present
//  in_ready    out  1                  FIFO can accept (not full)
//  in_op       in   alu_op_t           operation (alu_pkg)
//  in_a        in   N                  operand A
//  in_b        in   N                  operand B
//  in_tag      in   TAG_W              command tag
//  out_valid   out  1                  result register holds a result
//  out_ready   in   1                  consumer takes result
//  out_result  out  N                  registered ALU RESULT
//  out_carry   out  1                  registered ALU CARRY
//  out_zero    out  1                  registered ALU ZERO
//  out_tag     out  TAG_W              tag of the command that produced the result
//  fifo_count  out  $clog2(DEPTH+1)    commands currently buffered
//  busy        out  1                  fifo_count!=0 || out_valid
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - Reset: FIFO pointers and fifo_count=0; out_valid=0; out_result=0;
//    out_carry=0; out_zero=0; out_tag=0. in_ready reads 1 the cycle after reset.
//  - Reset mid-operation discards all buffered and registered commands. No result emerges.
//  - Push: in_valid && in_ready at an edge writes the command at the write pointer.
//    in_ready = (fifo_count != DEPTH) and does not depend on this cycle's pop.
//    When full, in_ready stays 0 even if a pop happens in the same cycle.
//  - Pop/issue: fire = (fifo_count != 0) && (!out_valid || out_ready).
//    On fire, the ALU output for the FIFO head is loaded into out_* and out_valid is set to 1.
//  - If out_ready && out_valid && !fire, out_valid is cleared to 0.
//  - While out_valid && !out_ready, all out_* signals hold stable.
//  - Latency: a command accepted at edge k into an empty, idle stage shows out_valid=1 after edge k+1.
//    There is no bypass from in_* to the ALU. Sustained throughput is 1 result per cycle.
//  - Simultaneous push+pop: fifo_count is unchanged; pointers wrap modulo DEPTH.
//  - Ordering: results leave strictly in acceptance order, and each tag is paired with its own result.
//  - Arithmetic follows the ALU exactly:
//    ADD: {carry,result} = A+B, (N+1)-bit.
//    SUB: {carry,result} = A-B, (N+1)-bit; carry=1 on borrow.
//    AND/OR/XOR: bitwise, carry=0.
//    SHIFT_LEFT/RIGHT: logical shift by B[3:0], carry=0.
//    Undefined op: result=0, carry=0, zero=1.
//    zero = (result == 0) for all ops.
//  - No inputs are sampled other than at push edges. in_* are don't-care when in_valid=0.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, fifo_count=0, no push; in_ready=1 after.
//  2 ADD A=16'hFFFF B=16'h0001 tag=3 into idle stage, out_ready=1
//    -> two edges later out_result=0, carry=1, zero=1, tag=3.
//  3 SUB A=3 B=5 then SHIFT_LEFT A=16'h0001 B=16'h0013
//    -> 16'hFFFE/carry=1/zero=0, then 16'h0008/carry=0.
//  4 out_ready=0, push 5 cmds (DEPTH=4) -> after 5 pushes: 1 in output reg, fifo_count=4, in_ready=0;
//    out_* stable; raising out_ready drains 5 results in order.
//  5 Random stream of 200 cmds, random in_valid/out_ready
//    -> results/tags match reference model in order; no loss or duplication.
//  6 Assert rst with fifo_count=3 and out_valid=1 -> next cycle all zero; first post-reset command
//    returns its own correct result.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffered command FIFO feeding a 16-bit ALU with a registered result stage
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
  } alu_op_t;
endpackage

module alu_core #(
  parameter int N = 16
) (
  input  alu_pkg::alu_op_t op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [N-1:0]     result,
  output logic             carry,
  output logic             zero
);
  import alu_pkg::*;
  // combinational ALU; encoding 3'd7 is undefined and yields zero
  always_comb begin
    carry = 1'b0;
    result = '0;
    case (op)
      ALU_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << b[3:0];
      ALU_SHR: result = a >> b[3:0];
      default: result = '0;
    endcase
    zero = result == '0;
  end
endmodule

module alu_issue_stage #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  alu_pkg::alu_op_t           in_op,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);
  import alu_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $bits(alu_op_t);
  localparam int EW = OW + 2 * N + TAG_W;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic push, fire;
  logic [N-1:0] alu_result;
  logic alu_carry, alu_zero;
  assign in_ready = fifo_count != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign fire = (fifo_count != '0) && (!out_valid || out_ready);
  assign busy = (fifo_count != '0) || out_valid;
  assign head = mem[rd_ptr];
  alu_core #(.N(N)) u_alu (
    .op     (alu_op_t'(head[EW-1 -: OW])),
    .a      (head[TAG_W+2*N-1 -: N]),
    .b      (head[TAG_W+N-1 -: N]),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );
  // command storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_op, in_a, in_b, in_tag};
  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(fire);
      fifo_count <= fifo_count + CW'(push) - CW'(fire);
    end
  end
  // result register: load on issue, drop once consumed, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_carry <= 1'b0;
      out_zero <= 1'b0;
      out_tag <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_result <= alu_result;
      out_carry <= alu_carry;
      out_zero <= alu_zero;
      out_tag <= head[TAG_W-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
